// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage initiator for a word-wide data memory. Accepts one RISC-V
// load/store request at a time (lb/lh/lw/lbu/lhu/sb/sh/sw) and turns it into
// word accesses on the memory port. Sub-word stores are done as
// read-modify-write (read old word, merge lane, write word back). Misaligned,
// out-of-range and illegal requests complete with resp_err and never touch
// memory.
//
// Ports
//   clk, rst_n      clock (posedge), asynchronous active-low reset
//   req_valid       request present
//   req_ready       high only while idle; request taken on valid & ready
//   req_we          1 = store, 0 = load
//   req_funct3      RISC-V width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   req_addr        byte address
//   req_wdata       store data (low byte / half used for sb / sh)
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load result; 0 for stores and errors; held
//   resp_err        error flag qualified by resp_valid; held
//   MemRead         memory read enable (memory read is combinational)
//   MemWrite        memory write enable (memory writes on posedge)
//   addr            word-aligned memory address
//   write_data      word written while MemWrite = 1, 0 otherwise
//   read_data       word from memory, valid while MemRead = 1
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    // -------------------------------------------------------------------------
    // Request classification helpers
    // -------------------------------------------------------------------------

    // A request is rejected when its width code is unknown, it is misaligned
    // for its width, it is an unsigned store, or it falls outside memory.
    function automatic logic req_is_bad(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = a[0];
            F3_W:        bad = |a[1:0];
            default:     bad = 1'b1;
        endcase
        // Stores have no signedness; 100/101 are load-only encodings.
        if (we && f3[2]) bad = 1'b1;
        if (a >= ADDR_LIMIT) bad = 1'b1;
        return bad;
    endfunction

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'd0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Build the word to write back: the new byte/half replaces its lane in
    // the previously read word; a full-word store ignores the old word.
    function automatic logic [31:0] store_merge(input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wd);
        logic [31:0] merged;
        merged = old_word;
        case (size)
            2'b00: merged[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) merged[31:16] = wd[15:0];
                else         merged[15:0]  = wd[15:0];
            end
            default: merged = wd;
        endcase
        return merged;
    endfunction

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    state_t      state;
    state_t      next_state;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_old_word;

    logic        accept;
    logic        accept_bad;
    logic [31:0] word_addr;

    assign accept     = req_valid && (state == S_IDLE);
    assign accept_bad = req_is_bad(req_we, req_funct3, req_addr);
    assign word_addr  = {r_addr[31:2], 2'b00};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // values from before the edge, regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (accept_bad)
                        next_state = S_RESP;
                    else if (!req_we)
                        next_state = S_RD;
                    else if (req_funct3 == F3_W)
                        next_state = S_WR;
                    else
                        next_state = S_RD;   // sb/sh read the old word first
                end
            end
            S_RD:    next_state = r_we ? S_WR : S_RESP;
            S_WR:    next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        addr       = '0;
        write_data = '0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_RD: begin
                MemRead = 1'b1;
                addr    = word_addr;
            end
            S_WR: begin
                MemWrite   = 1'b1;
                addr       = word_addr;
                write_data = store_merge(r_funct3[1:0], r_addr[1:0],
                                         r_old_word, r_wdata);
            end
            S_RESP:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture: the request is frozen at accept so later changes on
    // req_* cannot disturb an operation in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // Old word for read-modify-write stores, taken at the end of RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_old_word <= '0;
        else if (state == S_RD && r_we) r_old_word <= read_data;
    end

    // -------------------------------------------------------------------------
    // Response registers. Updated only on the edge that enters RESP so the
    // previous result stays visible until the next completion. Errors are
    // the only path that enters RESP straight from IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (state != S_RESP && next_state == S_RESP) begin
            resp_err   <= (state == S_IDLE);
            resp_rdata <= (state == S_RD && !r_we)
                          ? load_extract(r_funct3, r_addr[1:0], read_data)
                          : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Drives load/store requests into mem_access_unit backed by a simple word
// memory. A byte-array reference model computes each expected response when
// the request is issued and queues it; a negedge monitor pops and compares
// whenever resp_valid is seen, and also watches the memory port protocol.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int MEM_BYTES = 1024;

    localparam bit [2:0] F_B  = 3'b000;
    localparam bit [2:0] F_H  = 3'b001;
    localparam bit [2:0] F_W  = 3'b010;
    localparam bit [2:0] F_BU = 3'b100;
    localparam bit [2:0] F_HU = 3'b101;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr   = '0;
    logic [31:0] req_wdata  = '0;

    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Backing data memory: combinational read, posedge write.
    bit [31:0] mem_words [MEM_BYTES/4];
    assign read_data = mem_words[addr[9:2]];
    always @(posedge clk) if (MemWrite) mem_words[addr[9:2]] <= write_data;

    // Reference memory kept as bytes.
    bit [7:0] ref_mem [MEM_BYTES];

    typedef struct {
        bit        err;
        bit [31:0] rdata;
        int        lat;
        int        acc;
        bit [31:0] a;
    } exp_t;

    exp_t exp_q[$];

    int checks     = 0;
    int errors     = 0;
    int resp_count = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: applies the request to ref_mem and returns the
    // expected completion (error flag, data, cycles from accept to response).
    function automatic void model(input bit we, input bit [2:0] f3,
                                  input bit [31:0] a, input bit [31:0] wd,
                                  output bit err, output bit [31:0] rd,
                                  output int lat);
        int size;
        bit uns;
        uns = f3[2];
        case (f3)
            F_B, F_BU: size = 1;
            F_H, F_HU: size = 2;
            F_W:       size = 4;
            default:   size = 0;
        endcase
        err = 1'b0;
        if (size == 0)              err = 1'b1;
        else if (a >= MEM_BYTES)    err = 1'b1;
        else if ((a % size) != 0)   err = 1'b1;
        else if (we && uns)         err = 1'b1;
        rd = '0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            for (int i = 0; i < size; i++) rd |= 32'(ref_mem[a + i]) << (8 * i);
            if (!uns && size < 4 && rd[8 * size - 1]) rd |= 32'hFFFF_FFFF << (8 * size);
            lat = 2;
        end else begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8 * i +: 8];
            lat = (size == 4) ? 2 : 3;
        end
    endfunction

    // Monitor: port protocol every cycle, response scoreboard on resp_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'd0);
            if (!MemWrite) check("wdata_zero_outside_wr", write_data, 32'd0);
            if (exp_q.size() > 0 && exp_q[0].err)
                check("err_no_mem_access", {30'b0, MemRead, MemWrite}, 32'd0);
            if ((MemRead || MemWrite) && exp_q.size() > 0)
                check("mem_addr", addr, {exp_q[0].a[31:2], 2'b00});
            if (resp_valid) begin
                resp_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_latency", 32'(cycle - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    // Present a request, wait for acceptance, queue its expected response.
    // With hold=1 req_valid stays high after acceptance (back-to-back mode).
    task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit hold);
        exp_t e;
        int budget;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        budget     = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, expected 1", budget);
            req_valid = 1'b0;
            return;
        end
        model(we, f3, a, wd, e.err, e.rdata, e.lat);
        e.acc = cycle + 1;
        e.a   = a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            // Scramble the request lines: the DUT must use its latched copy.
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bit        we;
        bit [2:0]  f3;
        bit [31:0] a;
        bit        hold;
        int        r;
        int        pulses_before;
        bit [31:0] w;

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_memread",    {31'b0, MemRead},    32'd0);
        check("rst_memwrite",   {31'b0, MemWrite},   32'd0);
        check("rst_addr",       addr,                32'd0);
        check("rst_write_data", write_data,          32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'b0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // sw then lw of the same word.
        issue(1'b1, F_W, 32'h10, 32'h1234_5678, 1'b0);
        wait_drain();
        check("sw_mem", mem_words[4], 32'h1234_5678);
        issue(1'b0, F_W, 32'h10, 32'h0, 1'b0);
        wait_drain();

        // sb then signed/unsigned byte loads.
        issue(1'b1, F_B, 32'h11, 32'hFFFF_FFAB, 1'b0);
        wait_drain();
        check("sb_mem", mem_words[4], 32'h1234_AB78);
        issue(1'b0, F_B,  32'h11, 32'h0, 1'b0);
        issue(1'b0, F_BU, 32'h11, 32'h0, 1'b0);
        wait_drain();

        // sh then signed/unsigned half loads.
        issue(1'b1, F_H, 32'h12, 32'h5555_BEEF, 1'b0);
        wait_drain();
        check("sh_mem", mem_words[4], 32'hBEEF_AB78);
        issue(1'b0, F_H,  32'h12, 32'h0, 1'b0);
        issue(1'b0, F_HU, 32'h12, 32'h0, 1'b0);
        wait_drain();

        // Error cases: no memory access, err=1, rdata=0.
        issue(1'b0, F_W,    32'h06,  32'h0,         1'b0);
        issue(1'b0, F_H,    32'h13,  32'h0,         1'b0);
        issue(1'b1, F_B,    32'h400, 32'h0000_00CC, 1'b0);
        issue(1'b1, 3'b100, 32'h10,  32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 3'b011, 32'h10,  32'h0,         1'b0);
        wait_drain();
        check("err_mem_untouched", mem_words[4], 32'hBEEF_AB78);

        // Reset in the RD cycle of an sh: enables drop at once, no write,
        // no response, ready after release.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F_H;
        req_addr   = 32'h12;
        req_wdata  = 32'h0000_1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rstmid_memread_before", {31'b0, MemRead}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_memread",    {31'b0, MemRead},    32'd0);
        check("rstmid_memwrite",   {31'b0, MemWrite},   32'd0);
        check("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rstmid_resp_rdata", resp_rdata,          32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
        pulses_before = resp_count;
        repeat (4) @(negedge clk);
        check("rstmid_no_resp", 32'(resp_count - pulses_before), 32'd0);
        check("rstmid_mem_unchanged", mem_words[4], 32'hBEEF_AB78);

        // Three back-to-back requests with req_valid held high.
        pulses_before = resp_count;
        issue(1'b0, F_W, 32'h10, 32'h0,         1'b1);
        issue(1'b1, F_B, 32'h23, 32'h0000_005A, 1'b1);
        issue(1'b0, F_B, 32'h23, 32'h0,         1'b0);
        wait_drain();
        check("b2b_pulses", 32'(resp_count - pulses_before), 32'd3);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 19);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = MEM_BYTES - $urandom_range(0, 8);
            else             a = $urandom_range(0, 63);
            hold = ($urandom_range(0, 3) == 0) && (i != 299);
            issue(we, f3, a, $urandom, hold);
        end
        wait_drain();

        // Final memory image against the reference bytes.
        for (int k = 0; k < MEM_BYTES / 4; k++) begin
            w = {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]};
            check($sformatf("mem_final[%0d]", k), mem_words[k], w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
